video_scan_doubler: RTL and testbench

//  Line-doubling stage directly downstream of the teletext character generator.

---
 rtl/video_scan_doubler.sv | 136 +++++++++++++
 tb/tb_video_scan_doubler.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/video_scan_doubler.sv
// Line doubler: captures 15.625 kHz RGB lines into a ping-pong buffer and replays
// each line twice at double pixel rate with regenerated HSYNC (31.25 kHz output).
module video_scan_doubler #(
  parameter int unsigned LINE_PIXELS    = 768,
  parameter int unsigned ADDR_W         = 10,
  parameter int unsigned OUT_HS_TICKS   = 48,
  parameter int unsigned OUT_BP_TICKS   = 40,
  parameter int unsigned OUT_LINE_TICKS = 1024
) (
  input  logic       CLK,
  input  logic       nRESET,
  input  logic       IN_PIX_EN,
  input  logic       OUT_PIX_EN,
  input  logic       HSYNC_IN,
  input  logic       VSYNC_IN,
  input  logic [2:0] RGB_IN,
  output logic       VGA_HSYNC,
  output logic       VGA_VSYNC,
  output logic [2:0] VGA_RGB,
  output logic       RESYNC
);

  // Write count and line length must reach LINE_PIXELS itself, hence one extra bit.
  localparam int unsigned X_W = ADDR_W + 1;
  localparam int unsigned T_W =
    $clog2(OUT_HS_TICKS + OUT_BP_TICKS + LINE_PIXELS + OUT_LINE_TICKS + 1);

  localparam logic [X_W-1:0] X_MAX    = X_W'(LINE_PIXELS);
  localparam logic [T_W-1:0] T_HS_END = T_W'(OUT_HS_TICKS - 1);
  localparam logic [T_W-1:0] T_BP_END = T_W'(OUT_HS_TICKS + OUT_BP_TICKS - 1);
  localparam logic [T_W-1:0] T_LAST   = T_W'(OUT_LINE_TICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SYNC   = 3'd1,
    S_BP     = 3'd2,
    S_ACTIVE = 3'd3,
    S_FRONT  = 3'd4
  } state_t;

  state_t           state;
  logic             pass;
  logic             wr_bank;
  logic             hs_q;
  logic             vs_q;
  logic [X_W-1:0]   wr_x;
  logic [X_W-1:0]   line_len;
  logic [ADDR_W-1:0] rd_addr;
  logic [T_W-1:0]   t;

  logic [2:0] mem [2**X_W];

  logic rise_c;
  logic wr_en_c;
  logic addr_last_c;
  logic line_end_c;

  assign rise_c      = HSYNC_IN & ~hs_q;
  assign wr_en_c     = IN_PIX_EN & ~HSYNC_IN & (wr_x < X_MAX);
  assign addr_last_c = ({1'b0, rd_addr} == (line_len - X_W'(1)));
  // Last tick of an output line: FRONT reaching the period, or ACTIVE overrunning it.
  assign line_end_c  = OUT_PIX_EN & (t >= T_LAST) &
                       ((state == S_FRONT) | ((state == S_ACTIVE) & addr_last_c));

  always_ff @(posedge CLK) begin
    if (wr_en_c) mem[{wr_bank, wr_x[ADDR_W-1:0]}] <= RGB_IN;
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state     <= S_IDLE;
      pass      <= 1'b0;
      wr_bank   <= 1'b0;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      wr_x      <= '0;
      line_len  <= '0;
      rd_addr   <= '0;
      t         <= '0;
      VGA_HSYNC <= 1'b0;
      VGA_VSYNC <= 1'b0;
      VGA_RGB   <= 3'd0;
      RESYNC    <= 1'b0;
    end else begin
      hs_q   <= HSYNC_IN;
      vs_q   <= VSYNC_IN;
      RESYNC <= rise_c & (state != S_IDLE) & ~line_end_c;

      if (wr_en_c) wr_x <= wr_x + X_W'(1);

      // Outputs trail the state/address by one output tick; the read bank is never written.
      if (OUT_PIX_EN) begin
        VGA_HSYNC <= (state == S_SYNC);
        VGA_RGB   <= (state == S_ACTIVE) ? mem[{~wr_bank, rd_addr}] : 3'd0;
      end

      if (rise_c) begin
        line_len  <= wr_x;
        wr_bank   <= ~wr_bank;
        wr_x      <= '0;
        state     <= S_SYNC;
        pass      <= 1'b0;
        t         <= '0;
        rd_addr   <= '0;
        VGA_VSYNC <= vs_q;
      end else if (line_end_c) begin
        t       <= '0;
        rd_addr <= '0;
        if (!pass) begin
          pass      <= 1'b1;
          state     <= S_SYNC;
          VGA_VSYNC <= vs_q;
        end else begin
          state <= S_IDLE;
        end
      end else if (OUT_PIX_EN && (state != S_IDLE)) begin
        t <= t + T_W'(1);
        case (state)
          S_SYNC: if (t >= T_HS_END) state <= S_BP;
          S_BP: begin
            if (t >= T_BP_END) begin
              rd_addr <= '0;
              state   <= (line_len == '0) ? S_FRONT : S_ACTIVE;
            end
          end
          S_ACTIVE: begin
            rd_addr <= rd_addr + ADDR_W'(1);
            if (addr_last_c) state <= S_FRONT;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_video_scan_doubler.sv
// Randomized bench for video_scan_doubler against a line-level reference model.
module tb_video_scan_doubler;

  localparam int LP = 8;
  localparam int HS = 2;
  localparam int BP = 1;
  localparam int LT = 16;

  logic       clk = 1'b0;
  logic       nreset;
  logic       in_pix_en;
  logic       out_pix_en;
  logic       hsync_in;
  logic       vsync_in;
  logic [2:0] rgb_in;
  logic       vga_hsync;
  logic       vga_vsync;
  logic [2:0] vga_rgb;
  logic       resync;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  video_scan_doubler #(
    .LINE_PIXELS   (LP),
    .ADDR_W        (3),
    .OUT_HS_TICKS  (HS),
    .OUT_BP_TICKS  (BP),
    .OUT_LINE_TICKS(LT)
  ) dut (
    .CLK       (clk),
    .nRESET    (nreset),
    .IN_PIX_EN (in_pix_en),
    .OUT_PIX_EN(out_pix_en),
    .HSYNC_IN  (hsync_in),
    .VSYNC_IN  (vsync_in),
    .RGB_IN    (rgb_in),
    .VGA_HSYNC (vga_hsync),
    .VGA_VSYNC (vga_vsync),
    .VGA_RGB   (vga_rgb),
    .RESYNC    (resync)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: each captured line (max LP pixels) becomes an output line of
  // max(LT, HS+BP+len) ticks -- HS sync, BP blank, pixels, blank -- shown twice.
  logic [2:0] cap[$];
  logic [2:0] play[$];
  bit         playing;
  int         i_tick;
  bit         hs_prev, vs_prev;
  bit         exp_hs, exp_rs, exp_vs;
  logic [2:0] exp_rgb;

  task automatic model_reset();
    cap.delete();
    play.delete();
    playing = 1'b0;
    i_tick  = 0;
    hs_prev = 1'b0;
    vs_prev = 1'b0;
    exp_hs  = 1'b0;
    exp_rs  = 1'b0;
    exp_vs  = 1'b0;
    exp_rgb = 3'd0;
  endtask

  task automatic model_step();
    int  len, ll, j;
    bit  rise, eol;
    rise = hsync_in && !hs_prev;
    len  = play.size();
    ll   = (HS + BP + len > LT) ? HS + BP + len : LT;
    if (playing && i_tick < 2 * ll) begin
      j       = i_tick % ll;
      exp_hs  = (j < HS);
      exp_rgb = (j >= HS + BP && j < HS + BP + len) ? play[j - HS - BP] : 3'd0;
    end else begin
      exp_hs  = 1'b0;
      exp_rgb = 3'd0;
    end
    eol    = playing && (i_tick == ll - 1 || i_tick == 2 * ll - 1);
    exp_rs = rise && playing && (i_tick < 2 * ll) && !eol;
    if (rise || (playing && i_tick == ll - 1)) exp_vs = vs_prev;
    if (rise) begin
      play    = cap;
      cap.delete();
      i_tick  = 0;
      playing = 1'b1;
    end else if (playing) begin
      i_tick++;
    end
    if (in_pix_en && !hsync_in && cap.size() < LP) cap.push_back(rgb_in);
    hs_prev = hsync_in;
    vs_prev = vsync_in;
  endtask

  initial forever begin
    @(posedge clk or negedge nreset);
    if (!nreset) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check_eq("hsync",  32'(vga_hsync), 32'(exp_hs));
      check_eq("rgb",    32'(vga_rgb),   32'(exp_rgb));
      check_eq("resync", 32'(resync),    32'(exp_rs));
      check_eq("vsync",  32'(vga_vsync), 32'(exp_vs));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One input line: strobes on odd cycles, HSYNC_IN high for the final two cycles.
  // mode 0: pixels 1,2,..,7,0; 1..7: constant colour; 8: random.
  task automatic send_line(input int n, input int mode, input int cycles, input bit vs_val);
    int sent = 0;
    for (int c = 0; c < cycles; c++) begin
      if (c == cycles / 2) vsync_in = vs_val;
      if (c >= cycles - 2) begin
        hsync_in  = 1'b1;
        in_pix_en = 1'b0;
      end else begin
        hsync_in  = 1'b0;
        in_pix_en = (c % 2 == 1) && (sent < n);
        if (in_pix_en) begin
          if (mode == 0)     rgb_in = 3'(sent + 1);
          else if (mode < 8) rgb_in = 3'(mode);
          else               rgb_in = 3'($urandom);
          sent++;
        end
      end
      tick();
    end
  endtask

  task automatic idle(input int cycles);
    hsync_in  = 1'b0;
    in_pix_en = 1'b0;
    repeat (cycles) tick();
  endtask

  task automatic check_zero(input string pfx);
    check_eq({pfx, "_hsync"},  32'(vga_hsync), 32'd0);
    check_eq({pfx, "_vsync"},  32'(vga_vsync), 32'd0);
    check_eq({pfx, "_rgb"},    32'(vga_rgb),   32'd0);
    check_eq({pfx, "_resync"}, 32'(resync),    32'd0);
  endtask

  initial begin
    nreset     = 1'b0;
    in_pix_en  = 1'b0;
    out_pix_en = 1'b1;
    hsync_in   = 1'b0;
    vsync_in   = 1'b0;
    rgb_in     = 3'd0;
    repeat (3) tick();
    check_zero("rst");
    nreset = 1'b1;
    chk_en = 1'b1;
    idle(4);

    send_line(8, 0, 32, 1'b0);   // 1..7,0
    send_line(8, 3, 32, 1'b0);   // all 3 written while previous line replays
    send_line(8, 6, 32, 1'b1);   // all 6; VSYNC_IN rises mid-line
    send_line(12, 8, 32, 1'b1);  // overflow: only first 8 kept
    send_line(6, 8, 22, 1'b0);   // edge at tick 5 of the second pass -> RESYNC
    send_line(5, 8, 16, 1'b0);   // edge coincides with end of first pass
    send_line(8, 8, 32, 1'b0);
    idle(100);                   // missing input: replay twice, then stay blank

    for (int k = 0; k < 14; k++)
      send_line($urandom_range(0, 12), 8, $urandom_range(12, 40), 1'($urandom));
    idle(70);

    // Reset in the middle of an ACTIVE region.
    send_line(8, 8, 32, 1'b1);
    repeat (6) tick();
    #2 nreset = 1'b0;
    #1 check_zero("midrst");
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    repeat (2) tick();
    nreset = 1'b1;
    idle(20);
    send_line(8, 0, 32, 1'b0);
    idle(80);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
